hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_MAX_CYCLES, default 34, max cycles in MDU_BUSY before watchdog fires.
REQ-002 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port id_rs1 / id_rs2  in  5 each  source registers of instruction in ID.
REQ-006 SHALL have port id_uses_rs1 / id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-007 SHALL have port ex_rd  in  5  destination of instruction in EX (ID/EX rd output).
REQ-008 SHALL have port ex_mem_to_reg  in  1  instruction in EX is a load (ID/EX mem_to_reg output).
REQ-009 SHALL have port ex_branch_taken  in  1  resolved taken branch/jump in EX.
REQ-010 SHALL have port ex_mdu_start  in  1  multi-cycle mul/div issued in EX.
REQ-011 SHALL have port mdu_done  in  1  MDU result valid, one-cycle pulse.
REQ-012 SHALL have port cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-013 SHALL have ports pc_hold, if_id_hold, id_ex_hold  out  1 each  hold register contents.
REQ-014 SHALL have ports if_id_flush, id_ex_flush  out  1 each  load bubble (all-zero) into register.
REQ-015 SHALL have port state  out  2  current FSM state.
REQ-016 SHALL have port mdu_timeout  out  1  sticky watchdog error.
REQ-017 SHALL have port stall_cnt  out  CNT_W  saturating count of cycles with pc_hold=1.

Function
REQ-018 SHALL implement FSM states RUN=2'd0, MDU_BUSY=2'd1, REDIRECT=2'd2; 2'd3 SHALL transition to RUN.
REQ-019 SHALL compute hold/flush outputs combinationally from state and current-cycle inputs, zero latency.
REQ-020 In RUN, load-use = ex_mem_to_reg && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)); SHALL assert pc_hold, if_id_hold, id_ex_flush for that cycle only; state stays RUN.
REQ-021 In RUN, ex_branch_taken SHALL assert if_id_flush and id_ex_flush, suppress load-use outputs, and go to REDIRECT.
REQ-022 In REDIRECT, SHALL assert if_id_flush for exactly one cycle, ignore all hazard inputs, and return to RUN.
REQ-023 In RUN, ex_mdu_start (without branch) SHALL assert pc_hold, if_id_hold, id_ex_hold same cycle, suppress load-use, go to MDU_BUSY.
REQ-024 Priority in RUN: ex_branch_taken > ex_mdu_start > load-use.
REQ-025 In MDU_BUSY, SHALL hold pc_hold, if_id_hold, id_ex_hold high until mdu_done; in the mdu_done cycle all holds SHALL be 0 and next state RUN.
REQ-026 MDU_BUSY SHALL count cycles from 1; when count reaches MDU_MAX_CYCLES without mdu_done, SHALL set mdu_timeout, drop holds that cycle, go to RUN.
REQ-027 mdu_done outside MDU_BUSY SHALL be ignored; ex_branch_taken in MDU_BUSY SHALL be ignored.
REQ-028 id_ex_hold and id_ex_flush SHALL never both be 1.
REQ-029 stall_cnt SHALL increment when pc_hold=1, saturate at all-ones; cnt_clr SHALL zero it and win over increment.
REQ-030 mdu_timeout SHALL remain 1 until reset.

Reset
REQ-031 rst_n low SHALL immediately set state=RUN, watchdog count=0, stall_cnt=0, mdu_timeout=0.
REQ-032 While rst_n low, all hold/flush outputs SHALL be 0 regardless of inputs.
REQ-033 Reset during MDU_BUSY or REDIRECT SHALL abort the operation with no residual hold/flush after release.

Structure
REQ-034 State encodings and MDU_MAX_CYCLES default SHALL reside in shared package riscv_ctrl_pkg.
REQ-035 Saturating counter with clear SHALL be sub-module sat_counter (parameter W); watchdog counter is internal.

Verification
REQ-036 ex_mem_to_reg=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_hold=if_id_hold=id_ex_flush=1, stall_cnt=1, state RUN.
REQ-037 Same load-use but ex_rd=0 -> all outputs 0.
REQ-038 ex_branch_taken plus load-use in same cycle -> if_id_flush=id_ex_flush=1, no holds; next cycle REDIRECT with if_id_flush=1 only; then RUN.
REQ-039 ex_mdu_start, mdu_done 10 cycles later -> holds high 10 cycles, 0 in done cycle, stall_cnt=10.
REQ-040 ex_mdu_start, no mdu_done -> holds for 33 cycles, mdu_timeout=1 at cycle 34, state RUN; stays 1 until rst_n.
REQ-041 rst_n low mid MDU_BUSY -> state RUN, outputs 0, stall_cnt=0 same cycle; cnt_clr with pc_hold -> stall_cnt=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path definitions for the pipeline hazard controller.
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam int unsigned MDU_MAX_CYCLES_DEF = 34;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    // x0 is never a real dependency.
    function automatic logic load_use(
        input logic       mem_to_reg,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_to_reg && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals: ID/EX observations in, hold/flush controls out.
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_to_reg;
    logic       ex_branch_taken;
    logic       ex_mdu_start;
    logic       mdu_done;

    logic       pc_hold;
    logic       if_id_hold;
    logic       id_ex_hold;
    logic       if_id_flush;
    logic       id_ex_flush;

    // Pipeline datapath side
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_to_reg, ex_branch_taken, ex_mdu_start, mdu_done,
        input  pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush
    );

    // Hazard controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_to_reg, ex_branch_taken, ex_mdu_start, mdu_done,
        output pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch redirect,
// multi-cycle MDU stall with watchdog, and a stall-cycle counter.
module hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MDU_MAX_CYCLES = MDU_MAX_CYCLES_DEF,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz,
    input  logic             cnt_clr,
    output logic [1:0]       state,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WD_W = $clog2(MDU_MAX_CYCLES + 1);

    hz_state_e       state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    logic pc_hold_c, if_id_hold_c, id_ex_hold_c, if_id_flush_c, id_ex_flush_c;
    logic lu_c;

    assign lu_c = load_use(hz.ex_mem_to_reg, hz.ex_rd, hz.id_rs1, hz.id_rs2,
                           hz.id_uses_rs1, hz.id_uses_rs2);

    // Hazard decode: same-cycle hold/flush plus next state and watchdog
    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        to_d          = to_q;
        pc_hold_c     = 1'b0;
        if_id_hold_c  = 1'b0;
        id_ex_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                wd_d = '0;
                if (hz.ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = ST_REDIRECT;
                end else if (hz.ex_mdu_start) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                    wd_d         = WD_W'(1);
                    state_d      = ST_MDU_BUSY;
                end else if (lu_c) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            ST_MDU_BUSY: begin
                // wd_q is the 1-based index of the current busy cycle
                if (hz.mdu_done) begin
                    wd_d    = '0;
                    state_d = ST_RUN;
                end else if (wd_q == WD_W'(MDU_MAX_CYCLES)) begin
                    to_d    = 1'b1;
                    wd_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                    wd_d         = wd_q + WD_W'(1);
                end
            end
            ST_REDIRECT: begin
                if_id_flush_c = 1'b1;
                state_d       = ST_RUN;
            end
            default: begin
                wd_d    = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM, watchdog and sticky timeout registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    // Controls are forced low while reset is asserted
    assign hz.pc_hold     = rst_n & pc_hold_c;
    assign hz.if_id_hold  = rst_n & if_id_hold_c;
    assign hz.id_ex_hold  = rst_n & id_ex_hold_c;
    assign hz.if_id_flush = rst_n & if_id_flush_c;
    assign hz.id_ex_flush = rst_n & id_ex_flush_c;

    assign state       = state_q;
    assign mdu_timeout = to_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (hz.pc_hold),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-index model.
module tb_hazard_ctrl;

    localparam int MAX   = 34;
    localparam int S_RUN = 0;
    localparam int S_BSY = 1;
    localparam int S_RED = 2;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [1:0]  state;
    logic        mdu_timeout;
    logic [31:0] stall_cnt;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MDU_MAX_CYCLES (MAX),
        .CNT_W          (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (hz),
        .cnt_clr     (cnt_clr),
        .state       (state),
        .mdu_timeout (mdu_timeout),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: mode, cycle index of the MDU issue, sticky timeout, stall total
    int              cyc = 0;
    int              m_mode = S_RUN;
    int              m_t0 = 0;
    bit              m_to = 1'b0;
    longint unsigned m_stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit br, input bit start, input bit done,
                        input bit mtr, input bit u1, input bit u2, input bit clr,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        bit lu;
        bit e_pc, e_ifh, e_idh, e_iff, e_idf;
        int n;
        @(negedge clk);
        rst_n                = rst;
        hz.ex_branch_taken   = br;
        hz.ex_mdu_start      = start;
        hz.mdu_done          = done;
        hz.ex_mem_to_reg     = mtr;
        hz.id_uses_rs1       = u1;
        hz.id_uses_rs2       = u2;
        hz.id_rs1            = r1;
        hz.id_rs2            = r2;
        hz.ex_rd             = rd;
        cnt_clr              = clr;
        #1;
        {e_pc, e_ifh, e_idh, e_iff, e_idf} = '0;
        if (!rst) begin
            m_mode   = S_RUN;
            m_stalls = 0;
            m_to     = 1'b0;
        end
        lu = mtr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        if (rst) begin
            if (m_mode == S_RUN) begin
                if (br)         {e_iff, e_idf} = 2'b11;
                else if (start) {e_pc, e_ifh, e_idh} = 3'b111;
                else if (lu)    {e_pc, e_ifh, e_idf} = 3'b111;
            end else if (m_mode == S_BSY) begin
                n = cyc - m_t0;
                if (!done && n < MAX) {e_pc, e_ifh, e_idh} = 3'b111;
            end else begin
                e_iff = 1'b1;
            end
        end
        chk("pc_hold",     64'(hz.pc_hold),     64'(e_pc));
        chk("if_id_hold",  64'(hz.if_id_hold),  64'(e_ifh));
        chk("id_ex_hold",  64'(hz.id_ex_hold),  64'(e_idh));
        chk("if_id_flush", 64'(hz.if_id_flush), 64'(e_iff));
        chk("id_ex_flush", 64'(hz.id_ex_flush), 64'(e_idf));
        chk("hold_flush_excl", 64'(hz.id_ex_hold & hz.id_ex_flush), 64'(0));
        chk("state",       64'(state),          64'(m_mode));
        chk("mdu_timeout", 64'(mdu_timeout),    64'(m_to));
        chk("stall_cnt",   64'(stall_cnt),      m_stalls);
        if (rst) begin
            if (clr) m_stalls = 0;
            else if (e_pc && m_stalls != CNT_MAX) m_stalls++;
            case (m_mode)
                S_RUN: begin
                    if (br) m_mode = S_RED;
                    else if (start) begin
                        m_mode = S_BSY;
                        m_t0   = cyc;
                    end
                end
                S_BSY: begin
                    n = cyc - m_t0;
                    if (done) m_mode = S_RUN;
                    else if (n >= MAX) begin
                        m_to   = 1'b1;
                        m_mode = S_RUN;
                    end
                end
                default: m_mode = S_RUN;
            endcase
        end
        cyc++;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        bit rst, br, st, dn, mtr, u1, u2, clr;
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 1, 1, 1, 1, 1, 1, 0, 5'd3, 5'd3, 5'd3);
        idle();
        // Load-use on rs2, then the same with rd = x0
        step(1, 0, 0, 0, 1, 0, 1, 0, 5'd1, 5'd5, 5'd5);
        idle();
        step(1, 0, 0, 0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        idle();
        // Load-use on rs1 with rs1 unused -> no stall
        step(1, 0, 0, 0, 1, 0, 0, 0, 5'd7, 5'd2, 5'd7);
        // Branch together with load-use, then REDIRECT, then RUN
        step(1, 1, 0, 0, 1, 0, 1, 0, 5'd1, 5'd5, 5'd5);
        step(1, 0, 1, 1, 1, 0, 1, 0, 5'd1, 5'd5, 5'd5);
        idle();
        // MDU start beats load-use; done after 10 cycles
        step(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step(1, 0, 1, 0, 1, 1, 0, 0, 5'd4, 5'd0, 5'd4);
        repeat (9) step(1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        step(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        // MDU without done -> watchdog timeout, sticky until reset
        step(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        repeat (MAX) idle();
        repeat (3) idle();
        step(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        // Reset mid MDU_BUSY and mid REDIRECT
        step(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        repeat (4) idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        repeat (2) idle();
        step(1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle();
        // cnt_clr wins over a stalling cycle
        step(1, 0, 0, 0, 1, 1, 0, 0, 5'd9, 5'd0, 5'd9);
        step(1, 0, 0, 0, 1, 1, 0, 0, 5'd9, 5'd0, 5'd9);
        step(1, 0, 0, 0, 1, 1, 0, 1, 5'd9, 5'd0, 5'd9);
        idle();
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            br  = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 9) == 0);
            dn  = ($urandom_range(0, 7) == 0);
            mtr = ($urandom_range(0, 1) == 0);
            u1  = ($urandom_range(0, 1) == 0);
            u2  = ($urandom_range(0, 1) == 0);
            clr = ($urandom_range(0, 31) == 0);
            step(rst, br, st, dn, mtr, u1, u2, clr,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
